// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and load/store.
// One outstanding transaction; optional response timeout reports a hung memory as an error.
//
// state | meaning
// IDLE  | waiting for a request; combinational grant to one master
// REQ   | latched request presented on the memory port until accepted
// WAIT  | waiting for the memory response (timeout counter runs here)
// RSP   | response held for the owning master until it accepts
module mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ifu_req_valid,
   output logic                ifu_req_ready,
   input  logic [ADDR_W-1:0]   ifu_req_addr,
   output logic                ifu_rsp_valid,
   input  logic                ifu_rsp_ready,
   output logic [DATA_W-1:0]   ifu_rsp_data,
   output logic                ifu_rsp_err,
   input  logic                lsu_req_valid,
   output logic                lsu_req_ready,
   input  logic [ADDR_W-1:0]   lsu_req_addr,
   input  logic                lsu_req_wen,
   input  logic [DATA_W-1:0]   lsu_req_wdata,
   input  logic [DATA_W/8-1:0] lsu_req_wmask,
   output logic                lsu_rsp_valid,
   input  logic                lsu_rsp_ready,
   output logic [DATA_W-1:0]   lsu_rsp_data,
   output logic                lsu_rsp_err,
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic [ADDR_W-1:0]   mem_req_addr,
   output logic                mem_req_wen,
   output logic [DATA_W-1:0]   mem_req_wdata,
   output logic [DATA_W/8-1:0] mem_req_wmask,
   input  logic                mem_rsp_valid,
   output logic                mem_rsp_ready,
   input  logic [DATA_W-1:0]   mem_rsp_data
);
   localparam int MASK_W = DATA_W / 8;
   localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RSP} state_t;

   state_t              state, state_nxt;
   logic                last_lsu, owner_lsu;
   logic                grant_ifu, grant_lsu, timeout_hit;
   logic [ADDR_W-1:0]   addr_q;
   logic                wen_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [MASK_W-1:0]   wmask_q;
   logic [DATA_W-1:0]   rsp_data_q;
   logic                rsp_err_q;
   logic [CNT_W-1:0]    cnt;

   // On a tie the master that was not served last wins; last_lsu resets high so IFU wins first
   assign grant_ifu   = (state == IDLE) && ifu_req_valid && (!lsu_req_valid || last_lsu);
   assign grant_lsu   = (state == IDLE) && lsu_req_valid && !grant_ifu;
   assign timeout_hit = (TIMEOUT > 0) && (cnt == CNT_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (grant_ifu || grant_lsu) state_nxt = REQ;
         REQ:  if (mem_req_ready) state_nxt = WAIT;
         WAIT: if (mem_rsp_valid || timeout_hit) state_nxt = RSP;
         RSP:  if (owner_lsu ? lsu_rsp_ready : ifu_rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Grants are masked by reset so every output is low while reset is held
   always_comb begin
      ifu_req_ready = 1'b0;
      lsu_req_ready = 1'b0;
      mem_req_valid = 1'b0;
      mem_rsp_ready = 1'b0;
      ifu_rsp_valid = 1'b0;
      lsu_rsp_valid = 1'b0;
      case (state)
         IDLE: begin
            ifu_req_ready = grant_ifu && rst;
            lsu_req_ready = grant_lsu && rst;
         end
         REQ:  mem_req_valid = 1'b1;
         WAIT: mem_rsp_ready = 1'b1;
         RSP: begin
            ifu_rsp_valid = !owner_lsu;
            lsu_rsp_valid = owner_lsu;
         end
         default: ;
      endcase
   end

   assign mem_req_addr  = addr_q;
   assign mem_req_wen   = wen_q;
   assign mem_req_wdata = wdata_q;
   assign mem_req_wmask = wmask_q;
   assign ifu_rsp_data  = ifu_rsp_valid ? rsp_data_q : '0;
   assign ifu_rsp_err   = ifu_rsp_valid && rsp_err_q;
   assign lsu_rsp_data  = lsu_rsp_valid ? rsp_data_q : '0;
   assign lsu_rsp_err   = lsu_rsp_valid && rsp_err_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_lsu   <= 1'b1;
         owner_lsu  <= 1'b0;
         addr_q     <= '0;
         wen_q      <= 1'b0;
         wdata_q    <= '0;
         wmask_q    <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
         cnt        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_ifu) begin
                  owner_lsu <= 1'b0;
                  last_lsu  <= 1'b0;
                  addr_q    <= ifu_req_addr;
                  wen_q     <= 1'b0;
                  wdata_q   <= '0;
                  wmask_q   <= '0;
               end else if (grant_lsu) begin
                  owner_lsu <= 1'b1;
                  last_lsu  <= 1'b1;
                  addr_q    <= lsu_req_addr;
                  wen_q     <= lsu_req_wen;
                  wdata_q   <= lsu_req_wdata;
                  wmask_q   <= lsu_req_wmask;
               end
            end
            REQ: if (mem_req_ready) cnt <= '0;
            WAIT: begin
               if (TIMEOUT > 0) cnt <= cnt + CNT_W'(1);
               // A real response in the timeout cycle takes priority over the error
               if (mem_rsp_valid) begin
                  rsp_data_q <= wen_q ? '0 : mem_rsp_data;
                  rsp_err_q  <= 1'b0;
               end else if (timeout_hit) begin
                  rsp_data_q <= '0;
                  rsp_err_q  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule
